sd_cmd_engine: RTL and testbench

Hardware sequencer for the SD card CMD line in native 1-bit mode. It accepts a command index and argument from a host-side requester, builds the 48-bit command frame with CRC7, and shifts it out on SD_CMD. It then optionally captures and checks a 48-bit response (R1/R3/R6/R7 format) and reports status. It sits between a requester (a Nios PIO or a hardware init FSM) and the top-level SD_CMD/SD_CLK pins, with the tristate buffer placed at the top level.

---
 rtl/sd_cmd_engine.sv | 209 ++++++++++++++++++++
 tb/tb_sd_cmd_engine.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_engine.sv
// SD card CMD-line sequencer: frames a command with CRC7, shifts it out on SD_CMD,
// then optionally receives and checks a 48-bit response.
module sd_cmd_engine #(
  parameter int unsigned DIV_HALF = 63,
  parameter int unsigned NCR_MAX  = 64
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic        cmd_start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic        resp_expect,
  output logic        busy,
  output logic        done,
  output logic [5:0]  resp_index,
  output logic [31:0] resp_data,
  output logic        err_timeout,
  output logic        err_crc,
  output logic        err_frame,
  output logic        SD_CLK,
  output logic        SD_CMD_OUT,
  output logic        SD_CMD_OE,
  input  logic        SD_CMD_IN
);

  localparam int unsigned DIV_W = (DIV_HALF > 0) ? $clog2(DIV_HALF + 1) : 1;
  localparam int unsigned NCR_W = $clog2(NCR_MAX + 1);
  localparam int unsigned CNT_W = (NCR_W > 6) ? NCR_W : 6;

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_RECV, S_GAP, S_DONE} state_t;

  // Serial CRC7 (x^7 + x^3 + 1), MSB first, zero seed
  function automatic logic [6:0] crc7(input logic [39:0] data);
    logic [6:0]  c;
    logic [39:0] d;
    logic        fb;
    c = '0;
    d = data;
    for (int i = 0; i < 40; i++) begin
      fb = d[39] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
      d  = {d[38:0], 1'b0};
    end
    return c;
  endfunction

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [47:0]        tx_sh_q, tx_sh_d;
  logic [46:0]        rx_sh_q, rx_sh_d;
  logic               rexp_q, rexp_d;
  logic               sd_clk_d, cmd_out_d, cmd_oe_d;
  logic               busy_d, done_d;
  logic [5:0]         resp_index_d;
  logic [31:0]        resp_data_d;
  logic               err_timeout_d, err_crc_d, err_frame_d;

  logic               wrap_c, rise_tick_c, fall_tick_c;
  logic [47:0]        tx_frame_c, rx_frame_c;

  assign wrap_c      = (div_cnt_q == DIV_W'(DIV_HALF));
  assign rise_tick_c = wrap_c && !SD_CLK;
  assign fall_tick_c = wrap_c && SD_CLK;
  assign tx_frame_c  = {2'b01, cmd_index, cmd_arg, crc7({2'b01, cmd_index, cmd_arg}), 1'b1};
  // Final response bit is taken live so the frame can be judged on the 48th edge
  assign rx_frame_c  = {rx_sh_q, SD_CMD_IN};

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      div_cnt_q   <= '0;
      cnt_q       <= '0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      rexp_q      <= 1'b0;
      SD_CLK      <= 1'b0;
      SD_CMD_OUT  <= 1'b1;
      SD_CMD_OE   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      resp_index  <= '0;
      resp_data   <= '0;
      err_timeout <= 1'b0;
      err_crc     <= 1'b0;
      err_frame   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      cnt_q       <= cnt_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      rexp_q      <= rexp_d;
      SD_CLK      <= sd_clk_d;
      SD_CMD_OUT  <= cmd_out_d;
      SD_CMD_OE   <= cmd_oe_d;
      busy        <= busy_d;
      done        <= done_d;
      resp_index  <= resp_index_d;
      resp_data   <= resp_data_d;
      err_timeout <= err_timeout_d;
      err_crc     <= err_crc_d;
      err_frame   <= err_frame_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    div_cnt_d     = wrap_c ? '0 : div_cnt_q + DIV_W'(1);
    sd_clk_d      = wrap_c ? !SD_CLK : SD_CLK;
    cnt_d         = cnt_q;
    tx_sh_d       = tx_sh_q;
    rx_sh_d       = rx_sh_q;
    rexp_d        = rexp_q;
    cmd_out_d     = SD_CMD_OUT;
    cmd_oe_d      = SD_CMD_OE;
    busy_d        = busy;
    done_d        = 1'b0;
    resp_index_d  = resp_index;
    resp_data_d   = resp_data;
    err_timeout_d = err_timeout;
    err_crc_d     = err_crc;
    err_frame_d   = err_frame;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (cmd_start) begin
          tx_sh_d       = tx_frame_c;
          rexp_d        = resp_expect;
          cnt_d         = '0;
          busy_d        = 1'b1;
          resp_index_d  = '0;
          resp_data_d   = '0;
          err_timeout_d = 1'b0;
          err_crc_d     = 1'b0;
          err_frame_d   = 1'b0;
          state_d       = S_SEND;
        end else begin
          state_d = S_IDLE;
        end
      end

      // 48 bits driven on falling edges; the 49th falling edge releases the line
      S_SEND: begin
        if (fall_tick_c) begin
          if (cnt_q == CNT_W'(48)) begin
            cmd_oe_d  = 1'b0;
            cmd_out_d = 1'b1;
            cnt_d     = '0;
            state_d   = rexp_q ? S_WAIT : S_GAP;
          end else begin
            cmd_oe_d  = 1'b1;
            cmd_out_d = tx_sh_q[47];
            tx_sh_d   = {tx_sh_q[46:0], 1'b1};
            cnt_d     = cnt_q + CNT_W'(1);
          end
        end
      end

      S_WAIT: begin
        if (rise_tick_c) begin
          if (!SD_CMD_IN) begin
            rx_sh_d = '0;
            cnt_d   = CNT_W'(1);
            state_d = S_RECV;
          end else if (cnt_q == CNT_W'(NCR_MAX - 1)) begin
            err_timeout_d = 1'b1;
            cnt_d         = '0;
            state_d       = S_GAP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_RECV: begin
        if (rise_tick_c) begin
          if (cnt_q == CNT_W'(47)) begin
            resp_index_d = rx_frame_c[45:40];
            resp_data_d  = rx_frame_c[39:8];
            err_crc_d    = (crc7(rx_frame_c[47:8]) != rx_frame_c[7:1]);
            err_frame_d  = rx_frame_c[46] || !rx_frame_c[0];
            cnt_d        = '0;
            state_d      = S_GAP;
          end else begin
            rx_sh_d = {rx_sh_q[45:0], SD_CMD_IN};
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end

      S_GAP: begin
        if (rise_tick_c) begin
          if (cnt_q == CNT_W'(7)) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Bench for sd_cmd_engine: directed and randomized commands against a card model
// and a frame-level reference built from polynomial division.
module tb_sd_cmd_engine;

  localparam int unsigned DIV_HALF = 1;
  localparam int unsigned NCR_MAX  = 64;
  localparam int          HALF     = 5;
  localparam int          P        = 2 * (DIV_HALF + 1);

  logic        CLOCK_50    = 1'b0;
  logic        RESET_N     = 1'b0;
  logic        cmd_start   = 1'b0;
  logic [5:0]  cmd_index   = '0;
  logic [31:0] cmd_arg     = '0;
  logic        resp_expect = 1'b0;
  logic        SD_CMD_IN   = 1'b1;
  logic        busy, done, err_timeout, err_crc, err_frame;
  logic        SD_CLK, SD_CMD_OUT, SD_CMD_OE;
  logic [5:0]  resp_index;
  logic [31:0] resp_data;

  always #HALF CLOCK_50 = ~CLOCK_50;

  sd_cmd_engine #(.DIV_HALF(DIV_HALF), .NCR_MAX(NCR_MAX)) dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .cmd_start(cmd_start), .cmd_index(cmd_index),
    .cmd_arg(cmd_arg), .resp_expect(resp_expect), .busy(busy), .done(done),
    .resp_index(resp_index), .resp_data(resp_data), .err_timeout(err_timeout),
    .err_crc(err_crc), .err_frame(err_frame), .SD_CLK(SD_CLK), .SD_CMD_OUT(SD_CMD_OUT),
    .SD_CMD_OE(SD_CMD_OE), .SD_CMD_IN(SD_CMD_IN)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          sd_rise_total = 0;
  int          tx_total = 0;
  logic [47:0] tx_bits = '0;
  int          oe_fall_mark = 0;
  int          done_total = 0;
  int          done_mark = 0;
  int          done_busy_total = 0;

  // Card-side view of the line: what it sees on each SD_CLK rising edge
  always @(posedge SD_CLK) begin
    sd_rise_total <= sd_rise_total + 1;
    if (SD_CMD_OE) begin
      tx_bits  <= {tx_bits[46:0], SD_CMD_OUT};
      tx_total <= tx_total + 1;
    end
  end

  always @(negedge SD_CMD_OE) oe_fall_mark <= sd_rise_total;

  always @(negedge CLOCK_50) begin
    if (done) begin
      done_total <= done_total + 1;
      done_mark  <= sd_rise_total;
      if (busy) done_busy_total <= done_busy_total + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // CRC7 as the remainder of (data * x^7) divided by x^7 + x^3 + 1
  function automatic logic [6:0] crc7_ref(input logic [39:0] d);
    logic [46:0] m;
    m = {d, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (m[i]) m = m ^ (47'h89 << (i - 7));
    return m[6:0];
  endfunction

  function automatic logic [47:0] model_frame(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b01, idx, arg, crc7_ref({2'b01, idx, arg}), 1'b1};
  endfunction

  function automatic logic [47:0] make_resp(input logic [5:0] idx, input logic [31:0] data);
    return {2'b00, idx, data, crc7_ref({2'b00, idx, data}), 1'b1};
  endfunction

  // Card replies so that its start bit is sampled on rising edge delay+1 after release
  task automatic card_drive(input logic [47:0] r, input int delay);
    int k;
    k = 0;
    while (SD_CMD_OE !== 1'b1 && k < 4 * P) begin @(negedge CLOCK_50); k++; end
    check("card_oe_rise", 64'(SD_CMD_OE), 64'(1));
    if (SD_CMD_OE !== 1'b1) return;
    k = 0;
    while (SD_CMD_OE !== 1'b0 && k < 52 * P) begin @(negedge CLOCK_50); k++; end
    check("card_oe_fall", 64'(SD_CMD_OE), 64'(0));
    if (SD_CMD_OE !== 1'b0) return;
    repeat (delay) @(negedge SD_CLK);
    for (int i = 47; i >= 0; i--) begin
      SD_CMD_IN = r[i];
      @(negedge SD_CLK);
    end
    SD_CMD_IN = 1'b1;
  endtask

  task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                         input logic rexp, input bit reply, input logic [47:0] r,
                         input int delay, input int poke, input bit has_want,
                         input logic [47:0] want);
    int          d0, t0, db0, k, exp_edges;
    logic        exp_to, exp_crc, exp_frm;
    logic [5:0]  exp_ri;
    logic [31:0] exp_rd;
    @(negedge CLOCK_50);
    check({tag, ":busy_idle"}, 64'(busy), 64'(0));
    d0  = done_total;
    t0  = tx_total;
    db0 = done_busy_total;
    cmd_index = idx; cmd_arg = arg; resp_expect = rexp; cmd_start = 1'b1;
    @(negedge CLOCK_50);
    cmd_start = 1'b0; cmd_index = '0; cmd_arg = '0; resp_expect = 1'b0;
    check({tag, ":busy_accept"}, 64'(busy), 64'(1));
    if (poke > 0) begin
      repeat (poke) @(negedge CLOCK_50);
      cmd_index = ~idx; cmd_arg = ~arg; resp_expect = 1'b1; cmd_start = 1'b1;
      @(negedge CLOCK_50);
      cmd_start = 1'b0; resp_expect = 1'b0;
    end
    if (rexp && reply) card_drive(r, delay);
    k = 0;
    while (done_total == d0 && k < 2000) begin @(negedge CLOCK_50); #1; k++; end
    check({tag, ":done_seen"}, 64'(done_total != d0), 64'(1));
    repeat (3) @(negedge CLOCK_50);
    #1;

    exp_to = 1'b0; exp_crc = 1'b0; exp_frm = 1'b0; exp_ri = '0; exp_rd = '0; exp_edges = 8;
    if (rexp) begin
      if (!reply || delay >= int'(NCR_MAX)) begin
        exp_to    = 1'b1;
        exp_edges = int'(NCR_MAX) + 8;
      end else begin
        exp_ri    = r[45:40];
        exp_rd    = r[39:8];
        exp_crc   = (crc7_ref(r[47:8]) != r[7:1]);
        exp_frm   = r[46] || !r[0];
        exp_edges = delay + 48 + 8;
      end
    end

    check({tag, ":done_pulses"}, 64'(done_total - d0), 64'(1));
    check({tag, ":busy_at_done"}, 64'(done_busy_total - db0), 64'(0));
    check({tag, ":tx_bitcount"}, 64'(tx_total - t0), 64'(48));
    check({tag, ":tx_frame"}, 64'(tx_bits), 64'(model_frame(idx, arg)));
    if (has_want) check({tag, ":tx_known"}, 64'(tx_bits), 64'(want));
    check({tag, ":edges_to_done"}, 64'(done_mark - oe_fall_mark), 64'(exp_edges));
    check({tag, ":oe_after"}, 64'(SD_CMD_OE), 64'(0));
    check({tag, ":busy_after"}, 64'(busy), 64'(0));
    check({tag, ":errs"}, 64'({err_timeout, err_crc, err_frame}), 64'({exp_to, exp_crc, exp_frm}));
    check({tag, ":resp_index"}, 64'(resp_index), 64'(exp_ri));
    check({tag, ":resp_data"}, 64'(resp_data), 64'(exp_rd));
  endtask

  initial begin
    #(2 * HALF * 80000);
    $display("FAIL watchdog: got no end of run, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    time         t0, t1, t2;
    int          d0;
    logic [47:0] r8;
    logic [5:0]  ridx;
    logic [31:0] rdat;
    logic [47:0] rr;
    int          mode;

    repeat (3) @(negedge CLOCK_50);
    check("rst_ctrl", 64'({SD_CLK, SD_CMD_OUT, SD_CMD_OE, busy, done, err_timeout, err_crc, err_frame}),
          64'(8'b0100_0000));
    check("rst_resp", 64'({resp_index, resp_data}), 64'(0));
    RESET_N = 1'b1;

    @(posedge SD_CLK); t0 = $time;
    @(negedge SD_CLK); t1 = $time;
    @(posedge SD_CLK); t2 = $time;
    check("sdclk_period", 64'(t2 - t0), 64'(P * 2 * HALF));
    check("sdclk_high", 64'(t1 - t0), 64'(P * HALF));

    // Card replies carry a correctly computed CRC7
    r8 = make_resp(6'd8, 32'h0000_01AA);
    run_cmd("cmd0", 6'd0, 32'h0, 1'b0, 1'b0, '0, 0, 0, 1'b1, 48'h40_0000_0000_95);
    run_cmd("cmd8", 6'd8, 32'h1AA, 1'b1, 1'b1, r8, 5, 0, 1'b1, 48'h48_0000_01AA_87);
    run_cmd("cmd17_to", 6'd17, 32'h0, 1'b1, 1'b0, '0, 0, 0, 1'b1, 48'h51_0000_0000_55);
    run_cmd("cmd8_bit20", 6'd8, 32'h1AA, 1'b1, 1'b1, r8 ^ (48'd1 << 20), 5, 0, 1'b0, '0);
    run_cmd("cmd8_endbit", 6'd8, 32'h1AA, 1'b1, 1'b1, r8 & ~48'd1, 5, 0, 1'b0, '0);
    run_cmd("ncr_last", 6'd8, 32'h1AA, 1'b1, 1'b1, r8, int'(NCR_MAX) - 1, 0, 1'b0, '0);
    run_cmd("ncr_over", 6'd8, 32'h1AA, 1'b1, 1'b1, r8, int'(NCR_MAX), 0, 1'b0, '0);
    run_cmd("ignore_2nd", 6'd0, 32'h0, 1'b0, 1'b0, '0, 0, 10 * P, 1'b1, 48'h40_0000_0000_95);

    // Reset in the middle of SEND
    @(negedge CLOCK_50);
    cmd_index = 6'd0; cmd_arg = 32'h0; resp_expect = 1'b0; cmd_start = 1'b1;
    @(negedge CLOCK_50);
    cmd_start = 1'b0;
    repeat (20 * P) @(negedge CLOCK_50);
    check("rst_mid:oe_before", 64'(SD_CMD_OE), 64'(1));
    #1;
    d0 = done_total;
    #1;
    RESET_N = 1'b0;
    #1;
    check("rst_mid:oe", 64'(SD_CMD_OE), 64'(0));
    check("rst_mid:busy", 64'(busy), 64'(0));
    repeat (3) @(negedge CLOCK_50);
    RESET_N = 1'b1;
    repeat (60 * P) @(negedge CLOCK_50);
    #1;
    check("rst_mid:no_done", 64'(done_total - d0), 64'(0));
    run_cmd("cmd0_after_rst", 6'd0, 32'h0, 1'b0, 1'b0, '0, 0, 0, 1'b1, 48'h40_0000_0000_95);

    for (int it = 0; it < 12; it++) begin
      ridx = 6'($urandom_range(0, 63));
      rdat = $urandom;
      rr   = make_resp(ridx, rdat);
      mode = int'($urandom_range(0, 4));
      case (mode)
        1: rr = rr ^ (48'd1 << $urandom_range(1, 45));
        2: rr[0] = 1'b0;
        3: rr[46] = 1'b1;
        default: ;
      endcase
      run_cmd("rand", 6'($urandom_range(0, 63)), $urandom, 1'($urandom_range(0, 3) != 0),
              mode != 4, rr, int'($urandom_range(0, NCR_MAX)), 0, 1'b0, '0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
